// File: rtl/saturate_scale_agc.sv
// Purpose: reduces NSAMP signed samples per clock to OUT_W-bit offset-binary codes with
//   per-lane magnitude and GT/LT threshold flags, and counts those flags over a
//   programmable window for the AGC loop.
// Latency: 2 clocks dat_i -> out_o/abs_o/gt_o/lt_o. Full throughput; the datapath never
//   stalls. Window results are held on count_valid_o until ack_i.
// Ports: clk_i, rst_ni (async, active low); en_i, dat_i (lane enable and samples);
//   thresh_i (magnitude threshold for flags); period_i, start_i, ack_i (window control);
//   out_o, abs_o, gt_o, lt_o (per-lane results); gt_count_o, lt_count_o,
//   count_valid_o, busy_o (window results and status).
module saturate_scale_agc #(
  parameter int NSAMP = 8,
  parameter int IN_W  = 18,
  parameter int OUT_W = 5,
  parameter int LSB   = 4,
  parameter int CNT_W = 24,
  parameter int AW    = CNT_W + $clog2(NSAMP + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic [NSAMP*IN_W-1:0]     dat_i,
  input  logic [OUT_W-2:0]          thresh_i,
  input  logic [CNT_W-1:0]          period_i,
  input  logic                      start_i,
  input  logic                      ack_i,
  output logic [NSAMP*OUT_W-1:0]    out_o,
  output logic [NSAMP*(OUT_W-1)-1:0] abs_o,
  output logic [NSAMP-1:0]          gt_o,
  output logic [NSAMP-1:0]          lt_o,
  output logic [AW-1:0]             gt_count_o,
  output logic [AW-1:0]             lt_count_o,
  output logic                      count_valid_o,
  output logic                      busy_o
);

  localparam int MW  = OUT_W - 1;           // magnitude width
  localparam int PW  = $clog2(NSAMP + 1);   // popcount width
  localparam int TOP = LSB + OUT_W - 2;     // highest input bit that lands in the code
  localparam logic [OUT_W-1:0] MID = {1'b1, {MW{1'b0}}};

  // ---------------- stage 1 ----------------
  logic [NSAMP*IN_W-1:0] dat_q;
  logic                  en_q;
  logic [NSAMP-1:0]      inb_d, inb_q;

  // A sample fits when everything from TOP up is pure sign extension.
  for (genvar k = 0; k < NSAMP; k++) begin : g_inb
    logic [IN_W-1-TOP:0] hi;
    assign hi       = dat_i[k*IN_W+TOP +: IN_W-TOP];
    assign inb_d[k] = (&hi) | ~(|hi);
  end

  // ---------------- stage 2 (combinational part) ----------------
  logic [NSAMP*OUT_W-1:0] out_d;
  logic [NSAMP*MW-1:0]    abs_d;
  logic [NSAMP-1:0]       gt_d, lt_d;

  for (genvar k = 0; k < NSAMP; k++) begin : g_lane
    logic          s, r, ge;
    logic [MW-1:0] b, m, mag;
    assign s   = dat_q[k*IN_W + IN_W - 1];
    assign b   = dat_q[k*IN_W + LSB +: MW];
    assign r   = dat_q[k*IN_W + LSB - 1];
    // The round bit is jammed into bit 0 instead of added, so the code can never
    // carry out of range and needs no second saturation.
    assign m   = {b[MW-1:1], b[0] | r};
    // One's-complement magnitude keeps the negative side symmetric with the positive.
    assign mag = s ? ~m : m;
    assign ge  = (mag >= thresh_i);

    assign out_d[k*OUT_W +: OUT_W] = !en_q     ? MID :
                                     !inb_q[k] ? {OUT_W{~s}} : {~s, m};
    assign abs_d[k*MW +: MW]       = !en_q     ? '0 :
                                     !inb_q[k] ? '1 : mag;
    // Saturated lanes are always flagged on their sign side.
    assign gt_d[k] = en_q & ~s & (~inb_q[k] | ge);
    assign lt_d[k] = en_q &  s & (~inb_q[k] | ge);
  end

  // Only sign, code and round bits of the registered samples are consumed.
  logic unused_dat;
  assign unused_dat = ^dat_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dat_q <= '0;
      en_q  <= 1'b0;
      inb_q <= '0;
      out_o <= {NSAMP{MID}};
      abs_o <= '0;
      gt_o  <= '0;
      lt_o  <= '0;
    end else begin
      dat_q <= dat_i;
      en_q  <= en_i;
      inb_q <= inb_d;
      out_o <= out_d;
      abs_o <= abs_d;
      gt_o  <= gt_d;
      lt_o  <= lt_d;
    end
  end

  // ---------------- window counting ----------------
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t state_q, state_d;

  logic [CNT_W-1:0] rem_q;
  logic [AW-1:0]    acc_gt_q, acc_lt_q;
  logic [PW-1:0]    pop_gt, pop_lt;
  logic [AW:0]      sum_gt, sum_lt;
  logic [AW-1:0]    sat_gt, sat_lt;
  logic             last;

  always_comb begin
    pop_gt = '0;
    pop_lt = '0;
    for (int k = 0; k < NSAMP; k++) begin
      pop_gt = pop_gt + PW'(gt_o[k]);
      pop_lt = pop_lt + PW'(lt_o[k]);
    end
  end

  assign sum_gt = {1'b0, acc_gt_q} + (AW+1)'(pop_gt);
  assign sum_lt = {1'b0, acc_lt_q} + (AW+1)'(pop_lt);
  assign sat_gt = sum_gt[AW] ? '1 : sum_gt[AW-1:0];
  assign sat_lt = sum_lt[AW] ? '1 : sum_lt[AW-1:0];
  assign last   = (rem_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (last)    state_d = DONE;
      DONE:    if (ack_i)   state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q      <= '0;
      acc_gt_q   <= '0;
      acc_lt_q   <= '0;
      gt_count_o <= '0;
      lt_count_o <= '0;
    end else if (state_q == IDLE && start_i) begin
      // A zero period still runs a single-cycle window.
      rem_q    <= (period_i == '0) ? CNT_W'(1) : period_i;
      acc_gt_q <= '0;
      acc_lt_q <= '0;
    end else if (state_q == RUN) begin
      rem_q    <= rem_q - CNT_W'(1);
      acc_gt_q <= sat_gt;
      acc_lt_q <= sat_lt;
      if (last) begin
        gt_count_o <= sat_gt;
        lt_count_o <= sat_lt;
      end
    end
  end

  assign busy_o        = (state_q == RUN);
  assign count_valid_o = (state_q == DONE);

endmodule

// File: tb/tb_saturate_scale_agc.sv
module tb_saturate_scale_agc;
  localparam int NSAMP = 8;
  localparam int IN_W  = 18;
  localparam int OUT_W = 5;
  localparam int LSB   = 4;
  localparam int CNT_W = 24;
  localparam int AW    = CNT_W + $clog2(NSAMP + 1);
  localparam int MW    = OUT_W - 1;
  localparam int MAXM  = (1 << MW) - 1;
  localparam int HI    = (1 << (LSB + OUT_W - 2)) - 1;
  localparam int LO    = -(1 << (LSB + OUT_W - 2));
  localparam logic [OUT_W-1:0] MID = {1'b1, {MW{1'b0}}};

  logic                    clk_i, rst_ni, en_i, start_i, ack_i;
  logic [NSAMP*IN_W-1:0]   dat_i;
  logic [MW-1:0]           thresh_i;
  logic [CNT_W-1:0]        period_i;
  logic [NSAMP*OUT_W-1:0]  out_o;
  logic [NSAMP*MW-1:0]     abs_o;
  logic [NSAMP-1:0]        gt_o, lt_o;
  logic [AW-1:0]           gt_count_o, lt_count_o;
  logic                    count_valid_o, busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  saturate_scale_agc #(.NSAMP(NSAMP), .IN_W(IN_W), .OUT_W(OUT_W), .LSB(LSB), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .dat_i(dat_i), .thresh_i(thresh_i),
    .period_i(period_i), .start_i(start_i), .ack_i(ack_i), .out_o(out_o), .abs_o(abs_o),
    .gt_o(gt_o), .lt_o(lt_o), .gt_count_o(gt_count_o), .lt_count_o(lt_count_o),
    .count_valid_o(count_valid_o), .busy_o(busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_lane(input int k, input int v);
    dat_i[k*IN_W +: IN_W] = IN_W'(v);
  endtask

  task automatic all_lanes(input int v);
    for (int k = 0; k < NSAMP; k++) set_lane(k, v);
  endtask

  // Reference: quantise by arithmetic on the integer sample value.
  function automatic void lane_model(input int x, input logic en, input int th,
                                     output int o, output int a, output logic g, output logic l);
    int t, frac, m;
    o = 1 << MW; a = 0; g = 1'b0; l = 1'b0;
    if (en) begin
      if (x > HI) begin
        o = (1 << OUT_W) - 1; a = MAXM; g = 1'b1;
      end else if (x < LO) begin
        o = 0; a = MAXM; l = 1'b1;
      end else begin
        t    = x >>> LSB;                       // floor(x / 2^LSB)
        frac = x - t * (1 << LSB);
        m    = (t & MAXM) | ((frac >= (1 << (LSB - 1))) ? 1 : 0);
        if (x >= 0) begin o = (1 << MW) + m; a = m;        g = (a >= th); end
        else        begin o = m;             a = MAXM - m; l = (a >= th); end
      end
    end
  endfunction

  function automatic void model_vec(input logic [NSAMP*IN_W-1:0] d, input logic en, input logic [MW-1:0] th,
                                    output logic [NSAMP*OUT_W-1:0] eo, output logic [NSAMP*MW-1:0] ea,
                                    output logic [NSAMP-1:0] eg, output logic [NSAMP-1:0] el);
    int o, a;
    logic g, l;
    eo = '0; ea = '0; eg = '0; el = '0;
    for (int k = 0; k < NSAMP; k++) begin
      lane_model($signed(d[k*IN_W +: IN_W]), en, int'(th), o, a, g, l);
      eo[k*OUT_W +: OUT_W] = OUT_W'(o);
      ea[k*MW +: MW]       = MW'(a);
      eg[k] = g;
      el[k] = l;
    end
  endfunction

  task automatic drive_random(input int en_pct, input bit rand_th);
    for (int k = 0; k < NSAMP; k++) begin
      if ($urandom_range(0, 3) == 0) dat_i[k*IN_W +: IN_W] = IN_W'($urandom);
      else set_lane(k, int'($urandom_range(0, 280)) - 140);
    end
    en_i = (int'($urandom_range(0, 99)) < en_pct);
    if (rand_th) thresh_i = MW'($urandom_range(0, MAXM));
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; en_i = 1'b0; start_i = 1'b0; ack_i = 1'b0;
    dat_i = '0; thresh_i = MW'(8); period_i = '0;
    repeat (3) tick();
    n_checks++; if (out_o !== {NSAMP{MID}}) begin n_fail++; $display("FAIL reset_out: got %h expected %h", out_o, {NSAMP{MID}}); end
    n_checks++; if (abs_o !== '0) begin n_fail++; $display("FAIL reset_abs: got %h expected 0", abs_o); end
    n_checks++; if (gt_o !== '0 || lt_o !== '0) begin n_fail++; $display("FAIL reset_flags: got gt %h lt %h expected 0", gt_o, lt_o); end
    n_checks++; if (gt_count_o !== '0 || lt_count_o !== '0) begin n_fail++; $display("FAIL reset_counts: got %h/%h expected 0", gt_count_o, lt_count_o); end
    n_checks++; if (count_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_status: got valid %b busy %b expected 0 0", count_valid_o, busy_o); end
    // Release, then first en-high sample must surface two edges later.
    set_lane(0, 88); en_i = 1'b1;
    #2 rst_ni = 1'b1;
    tick();
    n_checks++; if (out_o[OUT_W-1:0] !== MID) begin n_fail++; $display("FAIL release_lat1: got %h expected %h", out_o[OUT_W-1:0], MID); end
    tick();
    n_checks++; if (out_o[OUT_W-1:0] !== 5'h15) begin n_fail++; $display("FAIL release_lat2: got %h expected 15", out_o[OUT_W-1:0]); end
  endtask

  task automatic test_values();
    all_lanes(0); set_lane(0, 88); set_lane(1, -88); en_i = 1'b1; thresh_i = MW'(8);
    tick(); tick();
    n_checks++; if (out_o[9:0] !== {5'h0B, 5'h15}) begin n_fail++; $display("FAIL val88_out: got %h expected 0b/15", out_o[9:0]); end
    n_checks++; if (abs_o[7:0] !== 8'h45) begin n_fail++; $display("FAIL val88_abs: got %h expected 45", abs_o[7:0]); end
    n_checks++; if (out_o[NSAMP*OUT_W-1:10] !== {(NSAMP-2){MID}}) begin n_fail++; $display("FAIL val88_zero_lanes: got %h", out_o[NSAMP*OUT_W-1:10]); end
    n_checks++; if (gt_o !== '0 || lt_o !== '0) begin n_fail++; $display("FAIL val88_flags: got gt %h lt %h expected 0", gt_o, lt_o); end
    // Jamming the round bit into bit 0 maps +127 to magnitude 7, below threshold 8.
    set_lane(0, 300); set_lane(1, -300); set_lane(2, 127);
    tick(); tick();
    n_checks++; if (out_o[14:0] !== {5'h17, 5'h00, 5'h1F}) begin n_fail++; $display("FAIL val300_out: got %h expected 17/00/1f", out_o[14:0]); end
    n_checks++; if (abs_o[11:0] !== 12'h7FF) begin n_fail++; $display("FAIL val300_abs: got %h expected 7ff", abs_o[11:0]); end
    n_checks++; if (gt_o !== 8'h01) begin n_fail++; $display("FAIL val300_gt: got %h expected 01", gt_o); end
    n_checks++; if (lt_o !== 8'h02) begin n_fail++; $display("FAIL val300_lt: got %h expected 02", lt_o); end
  endtask

  task automatic test_enable_off();
    drive_random(0, 1'b0); all_lanes(-5000); set_lane(3, 5000);
    tick(); tick();
    n_checks++; if (out_o !== {NSAMP{MID}}) begin n_fail++; $display("FAIL en_off_out: got %h expected %h", out_o, {NSAMP{MID}}); end
    n_checks++; if (abs_o !== '0 || gt_o !== '0 || lt_o !== '0) begin n_fail++; $display("FAIL en_off_abs_flags: got %h %h %h expected 0", abs_o, gt_o, lt_o); end
  endtask

  task automatic test_window();
    all_lanes(200); en_i = 1'b1; thresh_i = MW'(8); period_i = CNT_W'(4);
    tick(); tick();
    start_i = 1'b1; tick(); start_i = 1'b0;
    n_checks++; if (busy_o !== 1'b1 || count_valid_o !== 1'b0) begin n_fail++; $display("FAIL win_start: got busy %b valid %b expected 1 0", busy_o, count_valid_o); end
    for (int j = 1; j <= 4; j++) begin
      tick();
      n_checks++; if (count_valid_o !== (j == 4)) begin n_fail++; $display("FAIL win_valid[%0d]: got %b expected %b", j, count_valid_o, (j == 4)); end
    end
    n_checks++; if (gt_count_o !== AW'(32) || lt_count_o !== '0) begin n_fail++; $display("FAIL win_counts: got %0d/%0d expected 32/0", gt_count_o, lt_count_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL win_busy_done: got %b expected 0", busy_o); end
    for (int j = 0; j < 10; j++) begin
      tick();
      n_checks++; if (count_valid_o !== 1'b1 || gt_count_o !== AW'(32) || lt_count_o !== '0) begin
        n_fail++; $display("FAIL win_hold[%0d]: got valid %b counts %0d/%0d expected 1 32/0", j, count_valid_o, gt_count_o, lt_count_o); end
    end
    ack_i = 1'b1; tick(); ack_i = 1'b0;
    n_checks++; if (count_valid_o !== 1'b0) begin n_fail++; $display("FAIL win_ack: got %b expected 0", count_valid_o); end
  endtask

  task automatic test_period_zero();
    period_i = '0;
    start_i = 1'b1; tick(); start_i = 1'b0;
    tick();
    n_checks++; if (count_valid_o !== 1'b1 || gt_count_o !== AW'(8)) begin n_fail++; $display("FAIL p0: got valid %b gt %0d expected 1 8", count_valid_o, gt_count_o); end
    ack_i = 1'b1; tick(); ack_i = 1'b0;
  endtask

  task automatic test_start_in_run();
    period_i = CNT_W'(4);
    start_i = 1'b1; tick(); start_i = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      if (j == 2) begin start_i = 1'b1; ack_i = 1'b1; end
      tick();
      start_i = 1'b0; ack_i = 1'b0;
      n_checks++; if (count_valid_o !== (j == 4)) begin n_fail++; $display("FAIL run_restart[%0d]: got valid %b expected %b", j, count_valid_o, (j == 4)); end
    end
    n_checks++; if (gt_count_o !== AW'(32)) begin n_fail++; $display("FAIL run_restart_cnt: got %0d expected 32", gt_count_o); end
    ack_i = 1'b1; tick(); ack_i = 1'b0;
  endtask

  task automatic test_ack_start_done();
    period_i = CNT_W'(2);
    start_i = 1'b1; tick(); start_i = 1'b0;
    tick(); tick();
    n_checks++; if (count_valid_o !== 1'b1 || gt_count_o !== AW'(16)) begin n_fail++; $display("FAIL done_p2: got valid %b gt %0d expected 1 16", count_valid_o, gt_count_o); end
    start_i = 1'b1; ack_i = 1'b1; tick(); start_i = 1'b0; ack_i = 1'b0;
    n_checks++; if (count_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL done_ackstart: got valid %b busy %b expected 0 0", count_valid_o, busy_o); end
    for (int j = 0; j < 3; j++) begin
      tick();
      n_checks++; if (busy_o !== 1'b0 || count_valid_o !== 1'b0) begin n_fail++; $display("FAIL done_norestart[%0d]: got busy %b valid %b expected 0 0", j, busy_o, count_valid_o); end
    end
  endtask

  task automatic test_reset_mid_run();
    int seen_valid;
    all_lanes(200); en_i = 1'b1; period_i = CNT_W'(4);
    start_i = 1'b1; tick(); start_i = 1'b0;
    tick();
    #2 rst_ni = 1'b0;
    #1;
    n_checks++; if (busy_o !== 1'b0 || count_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_status: got busy %b valid %b expected 0 0", busy_o, count_valid_o); end
    n_checks++; if (out_o !== {NSAMP{MID}} || abs_o !== '0 || gt_o !== '0) begin n_fail++; $display("FAIL mid_rst_lanes: got out %h abs %h gt %h", out_o, abs_o, gt_o); end
    n_checks++; if (gt_count_o !== '0 || lt_count_o !== '0) begin n_fail++; $display("FAIL mid_rst_counts: got %0d/%0d expected 0", gt_count_o, lt_count_o); end
    tick();
    #3 rst_ni = 1'b1;
    seen_valid = 0;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (count_valid_o !== 1'b0) seen_valid++;
      if (j == 1) begin
        n_checks++; if (out_o !== {NSAMP{5'h1F}}) begin n_fail++; $display("FAIL mid_rst_refill: got %h expected all 1f", out_o); end
      end
    end
    n_checks++; if (seen_valid != 0) begin n_fail++; $display("FAIL mid_rst_novalid: got %0d valid cycles expected 0", seen_valid); end
    start_i = 1'b1; tick(); start_i = 1'b0;
    repeat (4) tick();
    n_checks++; if (count_valid_o !== 1'b1 || gt_count_o !== AW'(32) || lt_count_o !== '0) begin
      n_fail++; $display("FAIL mid_rst_rerun: got valid %b counts %0d/%0d expected 1 32/0", count_valid_o, gt_count_o, lt_count_o); end
    ack_i = 1'b1; tick(); ack_i = 1'b0;
  endtask

  // Random stream checked against the model; optionally runs one window starting at start_at.
  task automatic run_random(input string tag, input int n, input int start_at, input int per,
                            input int en_pct, input bit rand_th);
    logic [NSAMP*IN_W-1:0]  d1;
    logic                   e1;
    logic [MW-1:0]          th_e;
    logic [NSAMP*OUT_W-1:0] eo;
    logic [NSAMP*MW-1:0]    ea;
    logic [NSAMP-1:0]       eg, el;
    int wstart, pe, sum_gt, sum_lt;
    wstart = -1; sum_gt = 0; sum_lt = 0;
    pe = (per == 0) ? 1 : per;
    period_i = CNT_W'(per);
    drive_random(en_pct, rand_th);
    tick();
    d1 = dat_i; e1 = en_i;
    for (int i = 0; i < n; i++) begin
      drive_random(en_pct, rand_th);
      start_i = (i == start_at);
      th_e = thresh_i;
      tick();
      start_i = 1'b0;
      model_vec(d1, e1, th_e, eo, ea, eg, el);
      n_checks++; if (out_o !== eo) begin n_fail++; $display("FAIL %s_out[%0d]: got %h expected %h", tag, i, out_o, eo); end
      n_checks++; if (abs_o !== ea) begin n_fail++; $display("FAIL %s_abs[%0d]: got %h expected %h", tag, i, abs_o, ea); end
      n_checks++; if (gt_o !== eg || lt_o !== el) begin n_fail++; $display("FAIL %s_flags[%0d]: got %h/%h expected %h/%h", tag, i, gt_o, lt_o, eg, el); end
      if (i == start_at) wstart = i;
      if (wstart >= 0) begin
        if (i < wstart + pe) begin
          sum_gt += $countones(eg);
          sum_lt += $countones(el);
        end
        n_checks++; if (count_valid_o !== (i >= wstart + pe) || busy_o !== (i < wstart + pe)) begin
          n_fail++; $display("FAIL %s_status[%0d]: got valid %b busy %b expected %b %b", tag, i, count_valid_o, busy_o, (i >= wstart + pe), (i < wstart + pe)); end
      end
      d1 = dat_i; e1 = en_i;
    end
    if (start_at >= 0) begin
      n_checks++; if (gt_count_o !== AW'(sum_gt) || lt_count_o !== AW'(sum_lt)) begin
        n_fail++; $display("FAIL %s_counts: got %0d/%0d expected %0d/%0d", tag, gt_count_o, lt_count_o, sum_gt, sum_lt); end
      ack_i = 1'b1; tick(); ack_i = 1'b0;
      n_checks++; if (count_valid_o !== 1'b0) begin n_fail++; $display("FAIL %s_ack: got %b expected 0", tag, count_valid_o); end
    end
  endtask

  task automatic test_random();
    run_random("rand", 60, -1, 0, 80, 1'b1);
    run_random("win_rand", 40, 5, 20, 90, 1'b1);
    run_random("win_off", 20, 3, 6, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_values();
    test_enable_off();
    test_window();
    test_period_zero();
    test_start_in_run();
    test_ack_start_done();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
